shd0028_rx: RTL and testbench

- Receiver for the SHD0028 display serial link: oversamples SHD0028_DATA/CLK/LATCH_n/ENABLE_n with the system clock, deserializes 48-bit frames and decodes each 8-bit segment byte back to a 4-bit symbol code plus decimal point.
- Sits on the board loopback path as a display self-test and mirror: it captures exactly what the display driver shifted out, for comparison against the intended BCD value and for status LEDs.

---
 rtl/shd0028_pkg.sv | 39 +++
 rtl/shd0028_rx_seg_decode.sv | 40 ++++
 rtl/shd0028_rx.sv | 179 +++++++++++++++++
 tb/tb_shd0028_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shd0028_pkg.sv
// Shared definitions for the SHD0028 display link receiver.
//   - default frame length
//   - seven-segment patterns (abcdefg, a = MSB) for every symbol the driver emits
//   - the 4-bit symbol codes these patterns decode to
//   - receiver FSM state type
package shd0028_pkg;

  localparam int unsigned FRAME_BITS_DFLT = 48;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_STAR  = 7'b1100011;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_R     = 7'b0000101;
  localparam logic [6:0] SEG_H     = 7'b0110111;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_STAR  = 4'hA;
  localparam logic [3:0] CODE_C     = 4'hB;
  localparam logic [3:0] CODE_R     = 4'hC;
  localparam logic [3:0] CODE_H     = 4'hD;
  localparam logic [3:0] CODE_MINUS = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_e;

endpackage

// File: rtl/shd0028_rx_seg_decode.sv
// Seven-segment pattern to symbol code decoder (combinational).
//   seg  : segments abcdefg, a in bit 6
//   code : 4-bit symbol code (blank code for unknown patterns)
//   bad  : pattern matches no known symbol
module shd0028_seg_decode
  import shd0028_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);

  always_comb begin
    code = CODE_BLANK;
    bad  = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_STAR:  code = CODE_STAR;
      SEG_C:     code = CODE_C;
      SEG_R:     code = CODE_R;
      SEG_H:     code = CODE_H;
      SEG_MINUS: code = CODE_MINUS;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_BLANK;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shd0028_rx.sv
// SHD0028 display serial link receiver.
// Oversamples the link with CLK, deserializes frames (first bit -> FRAME[0])
// and decodes each byte into a symbol code plus decimal point.
//   CLK, RST_n        : system clock, synchronous active-low reset
//   SHD_DATA/CLK      : serial data / clock (data taken on clock rise)
//   SHD_LATCH_n       : rising edge ends a frame
//   SHD_ENABLE_n      : high = bus idle
//   FRAME             : last good raw frame
//   DIGIT_CODE/DP/BAD : per-byte symbol code, decimal point, unknown-pattern flag
//   FRAME_VALID       : pulse when FRAME/DIGIT_* update
//   ERR_LEN           : pulse on latch with wrong bit count
//   ERR_TIMEOUT       : pulse on serial clock stall mid-frame
module shd0028_rx
  import shd0028_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DFLT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    SHD_DATA,
  input  logic                    SHD_CLK,
  input  logic                    SHD_LATCH_n,
  input  logic                    SHD_ENABLE_n,
  output logic [FRAME_BITS-1:0]   FRAME,
  output logic [FRAME_BITS/2-1:0] DIGIT_CODE,
  output logic [FRAME_BITS/8-1:0] DIGIT_DP,
  output logic [FRAME_BITS/8-1:0] DIGIT_BAD,
  output logic                    FRAME_VALID,
  output logic                    ERR_LEN,
  output logic                    ERR_TIMEOUT
);

  localparam int unsigned NDIG  = FRAME_BITS / 8;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Pin bundle order: {enable_n, latch_n, sclk, data}; reset to bus-idle levels
  // so that leaving reset never fabricates an edge.
  localparam logic [3:0] PINS_IDLE = 4'b1100;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  prev_q, prev_d;
  rx_state_e                   state_q, state_d;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [FRAME_BITS-1:0]       frame_q, frame_d;
  logic [4*NDIG-1:0]           code_q, code_d;
  logic [NDIG-1:0]             dp_q, dp_d;
  logic [NDIG-1:0]             bad_q, bad_d;
  logic                        valid_q, valid_d;
  logic                        err_len_q, err_len_d;
  logic                        err_tmo_q, err_tmo_d;

  logic [3:0]        pins_s;
  logic              data_s, en_n_s, sclk_rise, latch_rise, shift_now;
  logic [4*NDIG-1:0] dec_code;
  logic [NDIG-1:0]   dec_dp, dec_bad;

  assign pins_s     = sync_q[SYNC_STAGES-1];
  assign data_s     = pins_s[0];
  assign en_n_s     = pins_s[3];
  assign sclk_rise  = pins_s[1] & ~prev_q[1];
  assign latch_rise = pins_s[2] & ~prev_q[2];
  assign shift_now  = sclk_rise & ~en_n_s;

  // Decoders look at the next shift-register value so a bit arriving in the
  // same cycle as the latch edge is part of the decoded frame.
  for (genvar k = 0; k < NDIG; k++) begin : g_dec
    shd0028_seg_decode u_dec (
      .seg  (shift_d[8*k+1 +: 7]),
      .code (dec_code[4*k +: 4]),
      .bad  (dec_bad[k])
    );
    assign dec_dp[k] = shift_d[8*k];
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], {SHD_ENABLE_n, SHD_LATCH_n, SHD_CLK, SHD_DATA}};
    prev_d    = pins_s;
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    frame_d   = frame_q;
    code_d    = code_q;
    dp_d      = dp_q;
    bad_d     = bad_q;
    valid_d   = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;

    if (shift_now) begin
      shift_d = {data_s, shift_q[FRAME_BITS-1:1]};
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (shift_now) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        tmo_d = shift_now ? '0 : tmo_q + TMO_W'(1);
        if (en_n_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (latch_rise) begin
          if (cnt_d == CNT_W'(FRAME_BITS)) begin
            frame_d = shift_d;
            code_d  = dec_code;
            dp_d    = dec_dp;
            bad_d   = dec_bad;
            valid_d = 1'b1;
          end else begin
            err_len_d = 1'b1;
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
          tmo_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      sync_q    <= {SYNC_STAGES{PINS_IDLE}};
      prev_q    <= PINS_IDLE;
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      frame_q   <= '0;
      code_q    <= '0;
      dp_q      <= '0;
      bad_q     <= '0;
      valid_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      frame_q   <= frame_d;
      code_q    <= code_d;
      dp_q      <= dp_d;
      bad_q     <= bad_d;
      valid_q   <= valid_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign FRAME       = frame_q;
  assign DIGIT_CODE  = code_q;
  assign DIGIT_DP    = dp_q;
  assign DIGIT_BAD   = bad_q;
  assign FRAME_VALID = valid_q;
  assign ERR_LEN     = err_len_q;
  assign ERR_TIMEOUT = err_tmo_q;

endmodule

// File: tb/tb_shd0028_rx.sv
module tb_shd0028_rx;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        SHD_DATA = 1'b0;
  logic        SHD_CLK = 1'b0;
  logic        SHD_LATCH_n = 1'b1;
  logic        SHD_ENABLE_n = 1'b1;
  logic [47:0] FRAME;
  logic [23:0] DIGIT_CODE;
  logic [5:0]  DIGIT_DP;
  logic [5:0]  DIGIT_BAD;
  logic        FRAME_VALID;
  logic        ERR_LEN;
  logic        ERR_TIMEOUT;

  shd0028_rx #(
    .FRAME_BITS  (48),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .SHD_DATA     (SHD_DATA),
    .SHD_CLK      (SHD_CLK),
    .SHD_LATCH_n  (SHD_LATCH_n),
    .SHD_ENABLE_n (SHD_ENABLE_n),
    .FRAME        (FRAME),
    .DIGIT_CODE   (DIGIT_CODE),
    .DIGIT_DP     (DIGIT_DP),
    .DIGIT_BAD    (DIGIT_BAD),
    .FRAME_VALID  (FRAME_VALID),
    .ERR_LEN      (ERR_LEN),
    .ERR_TIMEOUT  (ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // kind is one-hot {timeout, len, valid}
  typedef struct {
    logic [2:0]  kind;
    logic [47:0] frame;
    logic [23:0] code;
    logic [5:0]  dp;
    logic [5:0]  bad;
  } exp_t;

  exp_t sb[$];
  exp_t last_good;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [47:0] F_235C  = 48'h00DAF3B6C69C;
  localparam logic [47:0] F_124RH = 48'h0260DB660A6E;
  localparam logic [47:0] F_BAD2  = 48'h00DAF312C69C;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [7:0] b);
    logic [6:0] s;
    s = b[7:1];
    case (s)
      7'b1111110: return 5'h00;
      7'b0110000: return 5'h01;
      7'b1101101: return 5'h02;
      7'b1111001: return 5'h03;
      7'b0110011: return 5'h04;
      7'b1011011: return 5'h05;
      7'b1011111: return 5'h06;
      7'b1110000: return 5'h07;
      7'b1111111: return 5'h08;
      7'b1111011: return 5'h09;
      7'b1100011: return 5'h0A;
      7'b1001110: return 5'h0B;
      7'b0000101: return 5'h0C;
      7'b0110111: return 5'h0D;
      7'b0000001: return 5'h0E;
      7'b0000000: return 5'h0F;
      default:    return 5'h1F;
    endcase
  endfunction

  function automatic exp_t model_frame(input logic [47:0] f);
    exp_t e;
    logic [4:0] d;
    e.kind  = 3'b001;
    e.frame = f;
    for (int k = 0; k < 6; k++) begin
      d = ref_dec(f[8*k +: 8]);
      e.code[4*k +: 4] = d[3:0];
      e.bad[k]         = d[4];
      e.dp[k]          = f[8*k];
    end
    return e;
  endfunction

  // Every output pulse must be matched by the oldest pending expectation.
  always @(negedge CLK) begin
    logic [2:0] obs;
    exp_t e;
    obs = {ERR_TIMEOUT, ERR_LEN, FRAME_VALID};
    if (obs != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(obs), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'(obs), 64'(e.kind));
        chk("frame", 64'(FRAME), 64'(e.frame));
        chk("digit_code", 64'(DIGIT_CODE), 64'(e.code));
        chk("digit_dp", 64'(DIGIT_DP), 64'(e.dp));
        chk("digit_bad", 64'(DIGIT_BAD), 64'(e.bad));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit coincide);
    for (int i = 0; i < n; i++) begin
      SHD_CLK  = 1'b0;
      SHD_DATA = v[i];
      if (coincide && i == n - 1) SHD_LATCH_n = 1'b0;
      step(4);
      SHD_CLK = 1'b1;
      if (coincide && i == n - 1) SHD_LATCH_n = 1'b1;
      step(4);
    end
  endtask

  task automatic send_frame(input logic [63:0] v, input int n, input bit coincide);
    SHD_ENABLE_n = 1'b0;
    step(4);
    send_bits(v, n, coincide);
    if (!coincide) begin
      SHD_LATCH_n = 1'b0;
      step(4);
      SHD_LATCH_n = 1'b1;
    end
    step(8);
    SHD_ENABLE_n = 1'b1;
    SHD_CLK      = 1'b0;
    step(4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
    step(10);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] f, input int n, input bit coincide);
    exp_t e;
    if (n == 48) begin
      e = model_frame(f);
      last_good = e;
    end else begin
      e = last_good;
      e.kind = 3'b010;
    end
    sb.push_back(e);
    send_frame(64'(f), n, coincide);
    wait_drain(tag);
  endtask

  task automatic do_reset();
    RST_n        = 1'b0;
    SHD_ENABLE_n = 1'b1;
    SHD_CLK      = 1'b0;
    SHD_LATCH_n  = 1'b1;
    step(4);
    RST_n = 1'b1;
    step(4);
    last_good = '{kind: 3'b001, frame: '0, code: '0, dp: '0, bad: '0};
  endtask

  initial begin
    exp_t e;
    do_reset();
    chk("rst_frame", 64'(FRAME), 64'd0);
    chk("rst_code", 64'(DIGIT_CODE), 64'd0);
    chk("rst_dp", 64'(DIGIT_DP), 64'd0);
    chk("rst_bad", 64'(DIGIT_BAD), 64'd0);
    chk("rst_pulses", 64'({FRAME_VALID, ERR_LEN, ERR_TIMEOUT}), 64'd0);

    // Latch edge while idle: no pulse expected
    SHD_LATCH_n = 1'b0;
    step(4);
    SHD_LATCH_n = 1'b1;
    wait_drain("idle_latch");

    run_frame("f_23.5*C", F_235C, 48, 1'b0);
    run_frame("f_-12.4rH", F_124RH, 48, 1'b0);
    run_frame("len47", F_235C, 47, 1'b0);
    run_frame("len49", F_235C, 49, 1'b0);

    // Serial clock stall mid-frame
    e = last_good;
    e.kind = 3'b100;
    sb.push_back(e);
    SHD_ENABLE_n = 1'b0;
    step(4);
    send_bits(64'(F_235C), 20, 1'b0);
    wait_drain("timeout");
    SHD_ENABLE_n = 1'b1;
    SHD_CLK      = 1'b0;
    step(4);
    run_frame("after_timeout", F_235C, 48, 1'b0);

    run_frame("bad_byte2", F_BAD2, 48, 1'b0);

    // Reset in the middle of a frame discards it silently
    SHD_ENABLE_n = 1'b0;
    step(4);
    send_bits(64'(F_235C), 30, 1'b0);
    do_reset();
    chk("midrst_frame", 64'(FRAME), 64'd0);
    chk("midrst_code", 64'(DIGIT_CODE), 64'd0);
    run_frame("after_reset", F_124RH, 48, 1'b0);

    run_frame("coincident", F_235C, 48, 1'b1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
